operand_fetch_unit: RTL and testbench
=====================================

// Module: operand_fetch_unit
// PURPOSE
//  Owns the register-file port on the requester side: drives wr_rd_en and the addresses and collects read data.
//  Accepts one decoded instruction, fetches rs1/rs2 and hands the operands to execute under valid/ready.
//  Arbitrates writeback against reads. The RF does either a write or a read per cycle, never both.
//  Tracks in-flight destinations in a scoreboard, so RAW hazards stall instead of returning stale data.
// PARAMETERS
//  XLEN  32  data width of register values, PC and writeback data
//  NREG  32  architectural register count; register address width is $clog2(NREG)
// PORTS
//  clk            in   1     single clock, rising edge
//  rst            in   1     asynchronous, active-high reset
//  dec_valid      in   1     decode presents an instruction
//  dec_ready      out  1     unit can accept; high only in IDLE
//  dec_rs1/rs2    in   5     source register addresses
//  dec_use_rs1/2  in   1     instruction reads that source
//  dec_rd         in   5     destination address
//  dec_rd_we      in   1     instruction writes rd
//  dec_pc         in   XLEN  passthrough PC
//  wb_valid       in   1     writeback request; always accepted, no ready
//  wb_addr        in   5     writeback address
//  wb_data        in   XLEN  writeback data
//  rf_wr_rd_en    out  1     1 = RF write this cycle, 0 = RF read
//  rf_addr_wr     out  5     RF write address (= wb_addr)
//  rf_write_data  out  XLEN  RF write data (= wb_data)
//  rf_addr_rd1/2  out  5     RF read addresses (held rs1/rs2)
//  rf_read_1/2    in   XLEN  RF read data, valid the cycle after a read cycle
//  ex_valid       out  1     operands valid to execute
//  ex_ready       in   1     execute accepts
//  ex_op1/op2     out  XLEN  operand values
//  ex_rd, ex_rd_we, ex_pc   out  5/1/XLEN  passthrough fields
// BEHAVIOUR
//  Reset: state=IDLE, scoreboard all 0, ex_valid=0, ex_op1/op2/pc=0, ex_rd=0, ex_rd_we=0, rf_wr_rd_en=0.
//  Write path (combinational): rf_wr_rd_en = wb_valid && wb_addr!=0; writes to x0 are dropped entirely.
//  FSM:
//   IDLE: dec_ready=1. On dec_valid, latch the fields, go to CHECK.
//     Unused sources and rs==0 are marked captured with value 0.
//   CHECK: for each uncaptured source:
//     - pending and matching a write this cycle: handled per the macro (CONFIGURATION).
//     All captured -> OUT.
//     Else no uncaptured source pending and rf_wr_rd_en=0 -> read cycle, go to READ.
//     Else stay in CHECK (write priority; reads never starve writeback).
//   READ: capture rf_read_1/2 into uncaptured operands -> OUT.
//   OUT: ex_valid=1; outputs stable while ex_ready=0.
//     On ex_valid && ex_ready: set scoreboard[ex_rd] if ex_rd_we && ex_rd!=0; go to IDLE.
//  Latency: accept at edge N; ex_valid from N+3 with no hazard or collision; +1 cycle per deferred cycle.
//  Scoreboard clear: on a write to that address. Same-address set+clear in one cycle: set wins.
//  Simulation assertion: wb_valid to a non-pending, nonzero address is an error.
//  Reset mid-operation: returns to IDLE at once, drops the held instruction, clears the scoreboard.
// CONFIGURATION
//  OFU_WB_BYPASS_EN defined:
//   In CHECK, a pending source matching this cycle's write captures wb_data directly.
//   Its scoreboard bit clears the same edge.
//  Undefined:
//   No capture from wb_data; the source waits for its bit to clear, then reads the RF.
//   Costs 2 extra cycles per RAW hazard.
// STRUCTURE
//  Package ofu_pkg:
//   - REG_AW=$clog2(NREG) constant.
//   - ofu_state_e {IDLE, CHECK, READ, OUT}.
//   - operand-capture struct {logic got; logic [XLEN-1:0] val}.
//  Sub-module ofu_scoreboard: NREG-bit pending vector.
//   - set/clear ports with set-wins priority.
//   - two combinational pending lookups; bit 0 tied 0.
// TESTING
//  1 Write path: wb x5=0x00001234, then dec rs1=5, rs2=0, use both.
//    -> ex_op1=0x00001234, ex_op2=0, ex_valid 3 cycles after accept.
//  2 Collision: wb_valid to x1..x3 on 3 consecutive cycles during CHECK.
//    -> rf_wr_rd_en=1 all 3; read on the 4th; ex_valid delayed 3 cycles.
//  3 RAW: issue rd=7 rd_we=1; next instr rs1=7 stalls in CHECK; wb x7=0xCAFEF00D after 4 cycles.
//    -> bypass: ex_op1=0xCAFEF00D, ex_valid next cycle.
//    -> no bypass: ex_valid 2 cycles later, same value.
//  4 Backpressure: ex_ready=0 for 5 cycles.
//    -> ex_* stable, dec_ready=0; handshake on release, dec_ready=1 next cycle.
//  5 x0: wb x0=0xFFFFFFFF, then read rs1=0.
//    -> rf_wr_rd_en stays 0, ex_op1=0.
//  6 Reset mid-op: assert rst in READ with scoreboard[9]=1.
//    -> IDLE, ex_valid=0, rs1=9 later proceeds without stall.

Source files
------------

// File: rtl/ofu_pkg.sv
// Shared types and constants for the operand fetch unit.
// Register address width, FSM state encoding and the per-operand capture record.
package ofu_pkg;

  localparam int OFU_XLEN = 32;
  localparam int OFU_NREG = 32;
  localparam int REG_AW   = $clog2(OFU_NREG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    READ  = 2'd2,
    OUT   = 2'd3
  } ofu_state_e;

  // got = value is final, val = operand value
  typedef struct packed {
    logic                got;
    logic [OFU_XLEN-1:0] val;
  } operand_t;

  // A source needs no fetch when the instruction ignores it or it names x0.
  function automatic logic src_is_free(input logic use_src, input logic [REG_AW-1:0] addr);
    return !use_src || (addr == '0);
  endfunction

endpackage

// File: rtl/ofu_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// A bit is set when an instruction with a destination leaves for execute and
// cleared when writeback for that register arrives; set wins on a same-address
// collision. Register x0 is never pending.
module ofu_scoreboard
  import ofu_pkg::*;
#(
  parameter int NREG = OFU_NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic              pend_a,
  output logic              pend_b
);

  logic [NREG-1:0] pend_vec;

  assign pend_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_bit
      // Per-register pending flag; a new producer overrides a retiring one.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pend_vec[gi] <= 1'b0;
        end else if (set_en && (set_addr == REG_AW'(gi))) begin
          pend_vec[gi] <= 1'b1;
        end else if (clr_en && (clr_addr == REG_AW'(gi))) begin
          pend_vec[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign pend_a = pend_vec[rd_addr_a];
  assign pend_b = pend_vec[rd_addr_b];

`ifndef SYNTHESIS
  // Writeback must only target a register that some instruction is producing.
  always @(posedge clk) begin
    if (!rst && clr_en) begin
      assert (pend_vec[clr_addr]);
    end
  end
`endif

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch unit: accepts one decoded instruction, fetches rs1/rs2 from a
// single-port register file and presents the operands to execute.
// Writeback owns the RF port whenever it is active; reads take idle cycles.
// RAW hazards stall on a pending-destination scoreboard.
// Build option OFU_WB_BYPASS_EN: a stalled source captures the matching
// writeback data directly instead of waiting to re-read the RF.
// The operand record width follows ofu_pkg::OFU_XLEN, so XLEN must match it.
module operand_fetch_unit
  import ofu_pkg::*;
#(
  parameter int XLEN = OFU_XLEN,
  parameter int NREG = OFU_NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_rd_we,
  input  logic [XLEN-1:0]   dec_pc,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              rf_wr_rd_en,
  output logic [REG_AW-1:0] rf_addr_wr,
  output logic [XLEN-1:0]   rf_write_data,
  output logic [REG_AW-1:0] rf_addr_rd1,
  output logic [REG_AW-1:0] rf_addr_rd2,
  input  logic [XLEN-1:0]   rf_read_1,
  input  logic [XLEN-1:0]   rf_read_2,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_rd_we,
  output logic [XLEN-1:0]   ex_pc
);

  ofu_state_e        state_reg, state_next;
  operand_t          op1_reg, op1_next;
  operand_t          op2_reg, op2_next;
  logic [REG_AW-1:0] rs1_reg, rs2_reg, rd_reg;
  logic              rd_we_reg;
  logic [XLEN-1:0]   pc_reg;

  logic pend1, pend2;
  logic byp1, byp2;
  logic got1_after, got2_after;
  logic stall;
  logic ex_fire, sb_set;

  // Writeback path: x0 writes never reach the RF and never steal a cycle.
  assign rf_wr_rd_en   = wb_valid && (wb_addr != '0);
  assign rf_addr_wr    = wb_addr;
  assign rf_write_data = wb_data;
  assign rf_addr_rd1   = rs1_reg;
  assign rf_addr_rd2   = rs2_reg;

  assign dec_ready = (state_reg == IDLE);
  assign ex_valid  = (state_reg == OUT);
  assign ex_op1    = op1_reg.val;
  assign ex_op2    = op2_reg.val;
  assign ex_rd     = rd_reg;
  assign ex_rd_we  = rd_we_reg;
  assign ex_pc     = pc_reg;

  assign ex_fire = ex_valid && ex_ready;
  assign sb_set  = ex_fire && rd_we_reg && (rd_reg != '0);

  ofu_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (sb_set),
    .set_addr  (rd_reg),
    .clr_en    (rf_wr_rd_en),
    .clr_addr  (wb_addr),
    .rd_addr_a (rs1_reg),
    .rd_addr_b (rs2_reg),
    .pend_a    (pend1),
    .pend_b    (pend2)
  );

`ifdef OFU_WB_BYPASS_EN
  // A waiting source grabs the writeback value in the cycle it appears.
  assign byp1 = !op1_reg.got && pend1 && rf_wr_rd_en && (wb_addr == rs1_reg);
  assign byp2 = !op2_reg.got && pend2 && rf_wr_rd_en && (wb_addr == rs2_reg);
`else
  // Without bypass a waiting source only ever reads the RF after its bit clears.
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign got1_after = op1_reg.got || byp1;
  assign got2_after = op2_reg.got || byp2;
  assign stall      = (!got1_after && pend1) || (!got2_after && pend2);

  // State register; reset abandons any held instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and operand-capture logic.
  always_comb begin
    state_next = state_reg;
    op1_next   = op1_reg;
    op2_next   = op2_reg;
    unique case (state_reg)
      IDLE: begin
        if (dec_valid) begin
          state_next   = CHECK;
          op1_next.got = src_is_free(dec_use_rs1, dec_rs1);
          op1_next.val = '0;
          op2_next.got = src_is_free(dec_use_rs2, dec_rs2);
          op2_next.val = '0;
        end
      end
      CHECK: begin
        if (byp1) begin
          op1_next.got = 1'b1;
          op1_next.val = wb_data;
        end
        if (byp2) begin
          op2_next.got = 1'b1;
          op2_next.val = wb_data;
        end
        if (got1_after && got2_after) begin
          state_next = OUT;
        end else if (!stall && !rf_wr_rd_en) begin
          // The RF is idle this cycle, so it performs our read.
          state_next = READ;
        end
      end
      READ: begin
        if (!op1_reg.got) begin
          op1_next.got = 1'b1;
          op1_next.val = rf_read_1;
        end
        if (!op2_reg.got) begin
          op2_next.got = 1'b1;
          op2_next.val = rf_read_2;
        end
        state_next = OUT;
      end
      OUT: begin
        if (ex_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_reg <= '0;
      op2_reg <= '0;
    end else begin
      op1_reg <= op1_next;
      op2_reg <= op2_next;
    end
  end

  // Instruction fields held from accept until handoff to execute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_reg   <= '0;
      rs2_reg   <= '0;
      rd_reg    <= '0;
      rd_we_reg <= 1'b0;
      pc_reg    <= '0;
    end else if ((state_reg == IDLE) && dec_valid) begin
      rs1_reg   <= dec_rs1;
      rs2_reg   <= dec_rs2;
      rd_reg    <= dec_rd;
      rd_we_reg <= dec_rd_we;
      pc_reg    <= dec_pc;
    end
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit with a behavioural single-port RF.
module tb_operand_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_rd_we;
  logic [31:0] dec_pc;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_wr_rd_en;
  logic [4:0]  rf_addr_wr, rf_addr_rd1, rf_addr_rd2;
  logic [31:0] rf_write_data, rf_read_1, rf_read_2;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_op1, ex_op2, ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;

  int n_cmp = 0;
  int n_bad = 0;

  logic        rf_init;
  logic [31:0] rf_mem [0:31];

  operand_fetch_unit dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_pc(dec_pc),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_wr_rd_en(rf_wr_rd_en), .rf_addr_wr(rf_addr_wr), .rf_write_data(rf_write_data),
    .rf_addr_rd1(rf_addr_rd1), .rf_addr_rd2(rf_addr_rd2),
    .rf_read_1(rf_read_1), .rf_read_2(rf_read_2),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  // Register file model: write or registered read each cycle; garbage on write cycles.
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0;
      rf_read_1 <= 32'h0;
      rf_read_2 <= 32'h0;
    end else if (rf_wr_rd_en) begin
      rf_mem[rf_addr_wr] <= rf_write_data;
      rf_read_1 <= 32'hDEADBEEF;
      rf_read_2 <= 32'hDEADBEEF;
    end else begin
      rf_read_1 <= rf_mem[rf_addr_rd1];
      rf_read_2 <= rf_mem[rf_addr_rd2];
    end
  end

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we,
                       input logic [31:0] pc);
    @(negedge clk);
    dec_rs1 = rs1; dec_use_rs1 = u1; dec_rs2 = rs2; dec_use_rs2 = u2;
    dec_rd = rd; dec_rd_we = we; dec_pc = pc; dec_valid = 1'b1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_dec_ready: got %b need 1", dec_ready);
    end
    @(posedge clk);
    #1 dec_valid = 1'b0;
  endtask

  // Counts falling edges after the accept edge until ex_valid is seen (bounded).
  task automatic wait_out(input int start, output int lat);
    lat = start;
    do begin
      @(negedge clk);
      lat++;
    end while (ex_valid !== 1'b1 && lat < 40);
  endtask

  task automatic retire();
    @(posedge clk);
    #1;
  endtask

  // Issues a source-less producer so its rd becomes pending.
  task automatic make_pending(input logic [4:0] rd);
    int lat;
    issue(5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 32'h10);
    wait_out(0, lat);
    n_cmp++;
    if (lat != 2 || ex_rd !== rd || ex_rd_we !== 1'b1) begin
      n_bad++;
      $display("FAIL producer_x%0d: lat %0d rd %0d we %b need lat 2 rd %0d we 1", rd, lat, ex_rd, ex_rd_we, rd);
    end
    retire();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (dec_ready !== 1'b1 || ex_valid !== 1'b0 || ex_op1 !== 32'h0 || ex_op2 !== 32'h0 ||
        ex_pc !== 32'h0 || ex_rd !== 5'd0 || ex_rd_we !== 1'b0 || rf_wr_rd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: rdy %b v %b op1 %h op2 %h pc %h rd %0d we %b wr %b", dec_ready,
               ex_valid, ex_op1, ex_op2, ex_pc, ex_rd, ex_rd_we, rf_wr_rd_en);
    end
    $display("test_reset: dec_ready=%b ex_valid=%b", dec_ready, ex_valid);
  endtask

  task automatic test_write_path();
    int lat;
    make_pending(5'd5);
    @(negedge clk);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h00001234;
    #1;
    n_cmp++;
    if (rf_wr_rd_en !== 1'b1 || rf_addr_wr !== 5'd5 || rf_write_data !== 32'h00001234) begin
      n_bad++;
      $display("FAIL wb_port: en %b addr %0d data %h need 1 5 00001234", rf_wr_rd_en, rf_addr_wr, rf_write_data);
    end
    @(posedge clk);
    #1 wb_valid = 1'b0;
    issue(5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 32'h40);
    wait_out(0, lat);
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL write_path_latency: got %0d need 3", lat); end
    n_cmp++;
    if (ex_op1 !== 32'h00001234 || ex_op2 !== 32'h0 || ex_pc !== 32'h40) begin
      n_bad++;
      $display("FAIL write_path_ops: op1 %h op2 %h pc %h need 00001234 0 40", ex_op1, ex_op2, ex_pc);
    end
    $display("test_write_path: lat=%0d op1=%h op2=%h", lat, ex_op1, ex_op2);
    retire();
  endtask

  task automatic test_collision();
    int lat;
    logic [31:0] vals [1:3];
    vals[1] = 32'h11; vals[2] = 32'h22; vals[3] = 32'h33;
    make_pending(5'd1);
    make_pending(5'd2);
    make_pending(5'd3);
    issue(5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 32'h80);
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = vals[1];
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rf_wr_rd_en !== 1'b1 || ex_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL collision_wr_cycle%0d: wr %b valid %b need 1 0", i, rf_wr_rd_en, ex_valid);
      end
      @(posedge clk);
      #1;
      if (i < 3) begin
        wb_addr = 5'(i + 1); wb_data = vals[i+1];
      end else begin
        wb_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (rf_wr_rd_en !== 1'b0 || rf_addr_rd1 !== 5'd5 || rf_addr_rd2 !== 5'd1) begin
      n_bad++;
      $display("FAIL collision_read_cycle: wr %b rd1 %0d rd2 %0d need 0 5 1", rf_wr_rd_en, rf_addr_rd1, rf_addr_rd2);
    end
    wait_out(4, lat);
    n_cmp++;
    if (lat != 6) begin n_bad++; $display("FAIL collision_latency: got %0d need 6", lat); end
    n_cmp++;
    if (ex_op1 !== 32'h00001234 || ex_op2 !== 32'h00000011) begin
      n_bad++;
      $display("FAIL collision_ops: op1 %h op2 %h need 00001234 00000011", ex_op1, ex_op2);
    end
    $display("test_collision: lat=%0d op1=%h op2=%h", lat, ex_op1, ex_op2);
    retire();
  endtask

  task automatic test_raw();
    int lat;
    int exp_lat;
`ifdef OFU_WB_BYPASS_EN
    exp_lat = 5;
`else
    exp_lat = 7;
`endif
    make_pending(5'd7);
    issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'hC0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ex_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL raw_stall_cycle%0d: ex_valid %b need 0", i, ex_valid);
      end
      if (i == 4) begin
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFEF00D;
      end
    end
    @(posedge clk);
    #1 wb_valid = 1'b0;
    wait_out(4, lat);
    n_cmp++;
    if (lat != exp_lat) begin n_bad++; $display("FAIL raw_latency: got %0d need %0d", lat, exp_lat); end
    n_cmp++;
    if (ex_op1 !== 32'hCAFEF00D || ex_op2 !== 32'h0) begin
      n_bad++;
      $display("FAIL raw_ops: op1 %h op2 %h need cafef00d 0", ex_op1, ex_op2);
    end
    $display("test_raw: lat=%0d op1=%h", lat, ex_op1);
    retire();
  endtask

  task automatic test_backpressure();
    int lat;
    ex_ready = 1'b0;
    issue(5'd5, 1'b1, 5'd5, 1'b1, 5'd10, 1'b0, 32'h100);
    wait_out(0, lat);
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL bp_latency: got %0d need 3", lat); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (ex_valid !== 1'b1 || dec_ready !== 1'b0 || ex_op1 !== 32'h00001234 ||
          ex_op2 !== 32'h00001234 || ex_rd !== 5'd10 || ex_pc !== 32'h100) begin
        n_bad++;
        $display("FAIL bp_hold%0d: v %b rdy %b op1 %h op2 %h rd %0d pc %h", i, ex_valid,
                 dec_ready, ex_op1, ex_op2, ex_rd, ex_pc);
      end
    end
    ex_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (dec_ready !== 1'b1 || ex_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: rdy %b v %b need 1 0", dec_ready, ex_valid);
    end
    $display("test_backpressure: held 5 cycles, dec_ready=%b after release", dec_ready);
  endtask

  task automatic test_x0();
    int lat;
    @(negedge clk);
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    #1;
    n_cmp++;
    if (rf_wr_rd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL x0_write: rf_wr_rd_en %b need 0", rf_wr_rd_en);
    end
    @(posedge clk);
    #1 wb_valid = 1'b0;
    issue(5'd0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 32'h200);
    wait_out(0, lat);
    n_cmp++;
    if (lat != 3 || ex_op1 !== 32'h0 || ex_op2 !== 32'h00001234) begin
      n_bad++;
      $display("FAIL x0_read: lat %0d op1 %h op2 %h need 3 0 00001234", lat, ex_op1, ex_op2);
    end
    $display("test_x0: lat=%0d op1=%h op2=%h", lat, ex_op1, ex_op2);
    retire();
  endtask

  task automatic test_reset_midop();
    int lat;
    make_pending(5'd9);
    issue(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 32'h300);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1 || ex_valid !== 1'b0 || ex_op1 !== 32'h0 || ex_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL midop_reset: rdy %b v %b op1 %h pc %h need 1 0 0 0", dec_ready, ex_valid, ex_op1, ex_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h400);
    wait_out(0, lat);
    n_cmp++;
    if (lat != 3 || ex_op1 !== 32'h0 || ex_pc !== 32'h400) begin
      n_bad++;
      $display("FAIL midop_after: lat %0d op1 %h pc %h need 3 0 400", lat, ex_op1, ex_pc);
    end
    $display("test_reset_midop: lat=%0d after reset", lat);
    retire();
  endtask

  initial begin
    rst = 1'b1; rf_init = 1'b1;
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
    dec_rd = '0; dec_rd_we = 1'b0; dec_pc = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    ex_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rf_init = 1'b0;
    test_reset();
    test_write_path();
    test_collision();
    test_raw();
    test_backpressure();
    test_x0();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
